// File: rtl/ysyx_23060025_scoreboard_pkg.sv
// ysyx_23060025_scoreboard_pkg
// Shared definitions for the issue/retire scoreboard: CSR instruction type
// codes (from which the upstream decoders derive csr_wen), default sizing
// parameters and small helpers.
package ysyx_23060025_scoreboard_pkg;

    // CSR instruction classes seen by IDU/WBU
    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_CSRRW = 2'd1,
        CSR_CSRRS = 2'd2,
        CSR_ECALL = 2'd3
    } csr_type_e;

    localparam int unsigned SB_NREG  = 32;  // architectural GPRs
    localparam int unsigned SB_CNT_W = 2;   // per-register pending counter width
    localparam int unsigned SB_DEPTH = 4;   // max instructions in flight
    localparam int unsigned SB_REG_W = 5;   // GPR index width

    // Every non-NONE CSR class writes a CSR (ECALL writes mepc/mcause)
    function automatic logic csr_writes(csr_type_e t);
        return (t != CSR_NONE);
    endfunction

    // Width needed to hold 0..depth
    function automatic int unsigned count_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ysyx_23060025_scoreboard_if.sv
// ysyx_23060025_scoreboard_if
// Issue/retire/query bundle between IDU/WBU (master) and the scoreboard
// (slave).
//   issue_*   : IDU offer of an instruction, its destination and sources
//   wb_*      : WBU retirement of one instruction
//   flush_i   : synchronous clear of all pending state
//   busy_*_o  : pending-write status of the current sources
//   inflight_o: issued-but-not-retired count, err_o: sticky underflow flag
interface ysyx_23060025_scoreboard_if
    import ysyx_23060025_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
);
    localparam int unsigned IW = count_width(DEPTH);

    logic                flush_i;
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic                issue_wd_i;
    logic [SB_REG_W-1:0] issue_wreg_i;
    logic                issue_csr_wen_i;
    logic                issue_ren0_i;
    logic                issue_ren1_i;
    logic [SB_REG_W-1:0] issue_rsc0_i;
    logic [SB_REG_W-1:0] issue_rsc1_i;
    logic                issue_csr_ren_i;
    logic                wb_valid_i;
    logic                wb_wd_i;
    logic [SB_REG_W-1:0] wb_wreg_i;
    logic                wb_csr_wen_i;
    logic                busy_reg0_o;
    logic                busy_reg1_o;
    logic                busy_csr_o;
    logic [IW-1:0]       inflight_o;
    logic                err_o;

    modport master (
        output flush_i, issue_valid_i, issue_wd_i, issue_wreg_i, issue_csr_wen_i,
               issue_ren0_i, issue_ren1_i, issue_rsc0_i, issue_rsc1_i, issue_csr_ren_i,
               wb_valid_i, wb_wd_i, wb_wreg_i, wb_csr_wen_i,
        input  issue_ready_o, busy_reg0_o, busy_reg1_o, busy_csr_o, inflight_o, err_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_wd_i, issue_wreg_i, issue_csr_wen_i,
               issue_ren0_i, issue_ren1_i, issue_rsc0_i, issue_rsc1_i, issue_csr_ren_i,
               wb_valid_i, wb_wd_i, wb_wreg_i, wb_csr_wen_i,
        output issue_ready_o, busy_reg0_o, busy_reg1_o, busy_csr_o, inflight_o, err_o
    );

endinterface

// File: rtl/ysyx_23060025_sat_cnt.sv
// ysyx_23060025_sat_cnt
// Up/down counter saturating at 0 and MAXV, with synchronous clear.
//   clock, reset : clock, asynchronous active-high reset
//   i_clr        : clear to 0 (overrides inc/dec)
//   i_inc, i_dec : count up / down; both together leave the value unchanged
//   o_cnt        : current value
//   o_full       : value equals MAXV
//   o_udf        : a lone decrement hit 0 this cycle (value holds at 0)
module ysyx_23060025_sat_cnt #(
    parameter int unsigned W    = 2,
    parameter int unsigned MAXV = (1 << W) - 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_full,
    output logic         o_udf
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_next;
    logic         w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_full = (r_cnt == W'(MAXV));
    assign o_cnt  = r_cnt;
    // Underflow is not reported while clearing: a flush owns the cycle
    assign o_udf  = ~i_clr & i_dec & ~i_inc & w_zero;

    always_comb begin
        w_next = r_cnt;
        if (i_clr) begin
            w_next = '0;
        end else if (i_inc & ~i_dec & ~o_full) begin
            w_next = r_cnt + W'(1);
        end else if (i_dec & ~i_inc & ~w_zero) begin
            w_next = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

endmodule

// File: rtl/ysyx_23060025_scoreboard.sv
// ysyx_23060025_scoreboard
// Producer-side record of in-flight GPR and CSR writes. An entry is counted
// when IDU issues an instruction and removed when WBU retires it; IDU source
// ports get a "still pending" indication, and issue is throttled when a
// per-register counter or the global in-flight count is full.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : issue/retire/flush inputs, ready/busy/inflight/err outputs
module ysyx_23060025_scoreboard
    import ysyx_23060025_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = SB_NREG,
    parameter int unsigned CNT_W = SB_CNT_W,
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    ysyx_23060025_scoreboard_if.slave   bus
);

    localparam int unsigned IW = count_width(DEPTH);

    logic             w_ready;
    logic             w_fire;
    logic             w_iss_eff;
    logic             w_wb_eff;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_full;
    logic [NREG-1:0]  w_udf;

    logic [CNT_W-1:0] w_csr_cnt;
    logic             w_csr_full;
    logic             w_csr_udf;

    logic [IW-1:0]    w_inflight;
    logic             w_if_full;
    logic             w_if_udf;

    logic             r_err;

    // x0 writes are architecturally discarded, so they never count
    assign w_iss_eff = bus.issue_wd_i & (bus.issue_wreg_i != '0);
    assign w_wb_eff  = bus.wb_wd_i & (bus.wb_wreg_i != '0);

    // x0 has no counter; tie its slot to "never pending, never full"
    assign w_cnt[0]  = '0;
    assign w_full[0] = 1'b0;
    assign w_udf[0]  = 1'b0;

    // Ready looks only at registered state and current issue fields,
    // not at a retire happening in the same cycle.
    assign w_ready = ~w_if_full
                   & ~(w_iss_eff & w_full[bus.issue_wreg_i])
                   & ~(bus.issue_csr_wen_i & w_csr_full);
    assign w_fire  = bus.issue_valid_i & w_ready;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        ysyx_23060025_sat_cnt #(
            .W    (CNT_W),
            .MAXV ((1 << CNT_W) - 1)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .i_clr  (bus.flush_i),
            .i_inc  (w_fire & w_iss_eff & (bus.issue_wreg_i == SB_REG_W'(r))),
            .i_dec  (bus.wb_valid_i & w_wb_eff & (bus.wb_wreg_i == SB_REG_W'(r))),
            .o_cnt  (w_cnt[r]),
            .o_full (w_full[r]),
            .o_udf  (w_udf[r])
        );
    end

    ysyx_23060025_sat_cnt #(
        .W    (CNT_W),
        .MAXV ((1 << CNT_W) - 1)
    ) u_csr_cnt (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (bus.flush_i),
        .i_inc  (w_fire & bus.issue_csr_wen_i),
        .i_dec  (bus.wb_valid_i & bus.wb_csr_wen_i),
        .o_cnt  (w_csr_cnt),
        .o_full (w_csr_full),
        .o_udf  (w_csr_udf)
    );

    ysyx_23060025_sat_cnt #(
        .W    (IW),
        .MAXV (DEPTH)
    ) u_inflight (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (bus.flush_i),
        .i_inc  (w_fire),
        .i_dec  (bus.wb_valid_i),
        .o_cnt  (w_inflight),
        .o_full (w_if_full),
        .o_udf  (w_if_udf)
    );

    // Sticky: survives flush, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((|w_udf) | w_csr_udf | w_if_udf) begin
            r_err <= 1'b1;
        end
    end

    always_comb begin
        bus.issue_ready_o = w_ready;
        bus.busy_reg0_o   = bus.issue_ren0_i & (bus.issue_rsc0_i != '0)
                          & (w_cnt[bus.issue_rsc0_i] != '0);
        bus.busy_reg1_o   = bus.issue_ren1_i & (bus.issue_rsc1_i != '0)
                          & (w_cnt[bus.issue_rsc1_i] != '0);
        bus.busy_csr_o    = bus.issue_csr_ren_i & (w_csr_cnt != '0);
        bus.inflight_o    = w_inflight;
        bus.err_o         = r_err;
    end

endmodule

// File: tb/tb_ysyx_23060025_scoreboard.sv
// tb_ysyx_23060025_scoreboard
// Directed and randomized checks of the scoreboard against a counting model.
module tb_ysyx_23060025_scoreboard;

    localparam int unsigned NREG  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ysyx_23060025_scoreboard_if #(.DEPTH(DEPTH)) bus ();

    ysyx_23060025_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: pending writes per register, pending CSR writes,
    // instructions in flight, sticky error.
    int m_cnt [NREG];
    int m_csr;
    int m_infl;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(NREG); r++) m_cnt[r] = 0;
        m_csr  = 0;
        m_infl = 0;
        m_err  = 0;
    endtask

    function automatic bit m_ready();
        bit blk_reg, blk_csr;
        blk_reg = bus.issue_wd_i && bus.issue_wreg_i != 0 && m_cnt[bus.issue_wreg_i] == CMAX;
        blk_csr = bus.issue_csr_wen_i && m_csr == CMAX;
        return (m_infl < int'(DEPTH)) && !blk_reg && !blk_csr;
    endfunction

    function automatic int upd(input int c, input bit inc, input bit dec);
        if (inc && !dec) return c + 1;
        if (dec && !inc) begin
            if (c == 0) begin
                m_err = 1;
                return 0;
            end
            return c - 1;
        end
        return c;
    endfunction

    task automatic idle();
        bus.flush_i         = 1'b0;
        bus.issue_valid_i   = 1'b0;
        bus.issue_wd_i      = 1'b0;
        bus.issue_wreg_i    = '0;
        bus.issue_csr_wen_i = 1'b0;
        bus.issue_ren0_i    = 1'b0;
        bus.issue_ren1_i    = 1'b0;
        bus.issue_rsc0_i    = '0;
        bus.issue_rsc1_i    = '0;
        bus.issue_csr_ren_i = 1'b0;
        bus.wb_valid_i      = 1'b0;
        bus.wb_wd_i         = 1'b0;
        bus.wb_wreg_i       = '0;
        bus.wb_csr_wen_i    = 1'b0;
    endtask

    task automatic set_issue(input bit v, input bit wd, input int wreg, input bit csrw);
        bus.issue_valid_i   = v;
        bus.issue_wd_i      = wd;
        bus.issue_wreg_i    = 5'(wreg);
        bus.issue_csr_wen_i = csrw;
    endtask

    task automatic set_src(input bit ren0, input int rsc0, input bit ren1, input int rsc1,
                           input bit csrr);
        bus.issue_ren0_i    = ren0;
        bus.issue_rsc0_i    = 5'(rsc0);
        bus.issue_ren1_i    = ren1;
        bus.issue_rsc1_i    = 5'(rsc1);
        bus.issue_csr_ren_i = csrr;
    endtask

    task automatic set_wb(input bit v, input bit wd, input int wreg, input bit csrw);
        bus.wb_valid_i   = v;
        bus.wb_wd_i      = wd;
        bus.wb_wreg_i    = 5'(wreg);
        bus.wb_csr_wen_i = csrw;
    endtask

    task automatic check_outs();
        bit e0, e1, ec;
        e0 = bus.issue_ren0_i && bus.issue_rsc0_i != 0 && m_cnt[bus.issue_rsc0_i] != 0;
        e1 = bus.issue_ren1_i && bus.issue_rsc1_i != 0 && m_cnt[bus.issue_rsc1_i] != 0;
        ec = bus.issue_csr_ren_i && m_csr != 0;
        chk("ready",    32'(bus.issue_ready_o), 32'(m_ready()));
        chk("busy0",    32'(bus.busy_reg0_o),   32'(e0));
        chk("busy1",    32'(bus.busy_reg1_o),   32'(e1));
        chk("busy_csr", 32'(bus.busy_csr_o),    32'(ec));
        chk("inflight", 32'(bus.inflight_o),    32'(m_infl));
        chk("err",      32'(bus.err_o),         32'(m_err));
    endtask

    // Inputs are set one time unit after a rising edge; this checks the
    // combinational outputs, crosses the next edge and advances the model.
    task automatic tick();
        bit fire, wbv, wbe;
        #1;
        check_outs();
        fire = bus.issue_valid_i && m_ready();
        @(posedge clock);
        wbv = bus.wb_valid_i;
        if (bus.flush_i) begin
            for (int r = 0; r < int'(NREG); r++) m_cnt[r] = 0;
            m_csr  = 0;
            m_infl = 0;
        end else begin
            m_infl = upd(m_infl, fire, wbv);
            for (int r = 1; r < int'(NREG); r++) begin
                wbe = wbv && bus.wb_wd_i && bus.wb_wreg_i == 5'(r);
                m_cnt[r] = upd(m_cnt[r], fire && bus.issue_wd_i && bus.issue_wreg_i == 5'(r), wbe);
            end
            m_csr = upd(m_csr, fire && bus.issue_csr_wen_i, wbv && bus.wb_csr_wen_i);
        end
        #1;
    endtask

    initial begin
        int r;
        bit wd;
        model_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        set_src(1, 5, 1, 7, 1);
        #1;
        chk("reset_ready",    32'(bus.issue_ready_o), 32'd1);
        chk("reset_inflight", 32'(bus.inflight_o),    32'd0);
        chk("reset_busy0",    32'(bus.busy_reg0_o),   32'd0);
        chk("reset_err",      32'(bus.err_o),         32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Issue x5, see it busy next cycle, then retire it
        idle(); set_issue(1, 1, 5, 0); set_src(1, 5, 0, 0, 0); tick();
        idle(); set_src(1, 5, 1, 5, 0); tick();
        chk("x5_busy0", 32'(bus.busy_reg0_o), 32'd1);
        idle(); set_wb(1, 1, 5, 0); set_src(1, 5, 0, 0, 0); tick();
        idle(); set_src(1, 5, 0, 0, 0); tick();
        chk("x5_cleared", 32'(bus.busy_reg0_o), 32'd0);
        chk("x5_inflight", 32'(bus.inflight_o), 32'd0);

        // Three writes to x7 fill its counter; x8 still fits globally
        repeat (3) begin idle(); set_issue(1, 1, 7, 0); tick(); end
        idle(); set_issue(1, 1, 7, 0); #1;
        chk("x7_full_ready", 32'(bus.issue_ready_o), 32'd0);
        tick();
        idle(); set_issue(1, 1, 8, 0); #1;
        chk("x8_ready", 32'(bus.issue_ready_o), 32'd1);
        tick();
        idle(); set_issue(1, 1, 9, 0); #1;
        chk("depth_ready", 32'(bus.issue_ready_o), 32'd0);
        chk("depth_inflight", 32'(bus.inflight_o), 32'd4);
        tick();
        repeat (3) begin idle(); set_wb(1, 1, 7, 0); tick(); end
        idle(); set_wb(1, 1, 8, 0); tick();

        // Same-cycle issue and retire of x3 with one pending
        idle(); set_issue(1, 1, 3, 0); tick();
        idle(); set_issue(1, 1, 3, 0); set_wb(1, 1, 3, 0); set_src(1, 3, 0, 0, 0); tick();
        idle(); set_src(1, 3, 0, 0, 0); tick();
        chk("x3_net_busy", 32'(bus.busy_reg0_o), 32'd1);
        chk("x3_net_inflight", 32'(bus.inflight_o), 32'd1);
        idle(); set_wb(1, 1, 3, 0); tick();

        // Write to x0 is not tracked but still occupies a slot
        idle(); set_issue(1, 1, 0, 0); set_src(1, 0, 1, 0, 0); tick();
        idle(); set_src(1, 0, 1, 0, 0); tick();
        chk("x0_busy", 32'(bus.busy_reg0_o), 32'd0);
        chk("x0_inflight", 32'(bus.inflight_o), 32'd1);
        idle(); set_wb(1, 1, 0, 0); tick();

        // Fill the window (one CSR write), then flush with an issue offered
        idle(); set_issue(1, 1, 1, 1); tick();
        idle(); set_issue(1, 1, 2, 0); set_src(0, 0, 0, 0, 1); tick();
        chk("csr_busy", 32'(bus.busy_csr_o), 32'd1);
        idle(); set_issue(1, 1, 4, 0); tick();
        idle(); set_issue(1, 1, 6, 0); tick();
        idle(); set_issue(1, 1, 10, 0); #1;
        chk("four_ready", 32'(bus.issue_ready_o), 32'd0);
        bus.flush_i = 1'b1; tick();
        idle(); set_issue(1, 1, 10, 0); bus.flush_i = 1'b1; tick();
        idle(); set_src(1, 1, 1, 10, 1); tick();
        chk("flush_inflight", 32'(bus.inflight_o), 32'd0);
        chk("flush_busy1", 32'(bus.busy_reg1_o), 32'd0);
        chk("flush_busy_csr", 32'(bus.busy_csr_o), 32'd0);

        // Retire with nothing pending sets the sticky error
        idle(); set_wb(1, 1, 9, 0); tick();
        idle(); tick();
        chk("udf_err", 32'(bus.err_o), 32'd1);
        idle(); bus.flush_i = 1'b1; tick();
        idle(); tick();
        chk("err_after_flush", 32'(bus.err_o), 32'd1);

        // Asynchronous reset between clock edges
        idle(); set_issue(1, 1, 12, 0); tick();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("async_err", 32'(bus.err_o), 32'd0);
        chk("async_inflight", 32'(bus.inflight_o), 32'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Randomized traffic over x0..x7 with legal retirements
        for (int k = 0; k < 400; k++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                set_issue(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 4) == 0));
            set_src(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
            if (m_infl > 0 && $urandom_range(0, 2) == 0) begin
                r  = int'($urandom_range(1, 7));
                wd = (m_cnt[r] > 0);
                set_wb(1, wd, wd ? r : 0, (m_csr > 0) && ($urandom_range(0, 1) == 1));
            end
            bus.flush_i = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_scoreboard.md
# ysyx_23060025_scoreboard

Producer-side record of in-flight register and CSR writes for the ysyx_23060025 pipeline. An entry is created when IDU hands an instruction to EXU and retired when WBU commits it. The block answers "is this source still pending a write" for the IDU read ports, which is the write-side complement to the hazard/bypass unit. It also throttles issue when per-register or global in-flight capacity is exhausted.

## Interface
Parameters:
- NREG, 32: architectural GPRs tracked (x0 never tracked)
- CNT_W, 2: width of each per-register pending counter (max 2^CNT_W-1 writes in flight per rd)
- DEPTH, 4: max total instructions in flight (issued, not retired)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush_i  in  1  synchronous clear of all pending state (redirect/exception)
- issue_valid_i  in  1  IDU offers an instruction
- issue_ready_o  out  1  scoreboard can accept it; fire = valid & ready
- issue_wd_i  in  1  instruction writes a GPR
- issue_wreg_i  in  5  destination GPR
- issue_csr_wen_i  in  1  instruction writes a CSR (CSRRW/CSRRS/ECALL)
- issue_ren0_i, issue_ren1_i  in  1  source read enables
- issue_rsc0_i, issue_rsc1_i  in  5  source GPRs
- issue_csr_ren_i  in  1  instruction reads a CSR
- wb_valid_i  in  1  WBU retires one instruction this cycle
- wb_wd_i  in  1  retired instruction wrote a GPR
- wb_wreg_i  in  5  its destination
- wb_csr_wen_i  in  1  it wrote a CSR
- busy_reg0_o, busy_reg1_o  out  1  source 0/1 has a pending write
- busy_csr_o  out  1  a CSR write is pending
- inflight_o  out  3  current in-flight count (clog2(DEPTH+1))
- err_o  out  1  sticky: retire without matching issue

## Operation
- State: cnt[r] (CNT_W bits) for r=1..NREG-1; csr_cnt (CNT_W bits); inflight; err.
- Effective write: wd & (wreg != 0). x0 is never counted or reported busy.
- Issue fire: inflight +1; cnt[wreg] +1 if effective write; csr_cnt +1 if csr_wen.
- Retire (wb_valid_i): inflight -1; cnt[wreg] -1 if effective write; csr_cnt -1 if csr_wen.
- Same-cycle issue fire and retire on the same counter: net unchanged. The same applies to inflight.
- Underflow (retire decrementing a zero counter, or inflight==0): the counter holds at 0 and err_o is set. err_o clears only on reset.
- issue_ready_o = (inflight < DEPTH) & ~(issue_wd_i & wreg!=0 & cnt[wreg]==max) & ~(issue_csr_wen_i & csr_cnt==max). It does not look ahead at same-cycle retire.
- busy_regN_o = renN & rscN!=0 & cnt[rscN]!=0. busy_csr_o = csr_ren & csr_cnt!=0.
- Busy and ready outputs are combinational from registered counters plus current inputs. A same-cycle retire is not forwarded, so the bypass unit covers it.
- flush_i: all counters and inflight go to 0 next edge. It takes priority over simultaneous issue/retire. err is unaffected.

## Timing
- Reset values: all counters 0, inflight_o=0, err_o=0, issue_ready_o=1 (given legal inputs), busy_*_o=0.
- Counter update latency: 1 cycle. An issue at edge N makes busy visible from cycle N+1.
- Reset asserted mid-operation clears all state immediately, independent of the clock.
- issue_ready_o does not depend on issue_valid_i.

## Structure
- The shared define file holds the CSR type codes (CSR_CSRRW, CSR_CSRRS, CSR_ECALL), from which the issue/wb csr_wen is derived upstream.
- One sub-module, ysyx_23060025_sat_cnt: an up/down saturating counter with clear and an underflow flag. It is instantiated per GPR, for CSR, and for inflight (width-parameterised).

## Test plan
- Reset, then issue x5 write → cycle+1 busy_reg0_o=1 for rsc0=5. Retire x5 → next cycle busy=0, inflight_o=0.
- Issue three writes to x7 (CNT_W=2) → issue_ready_o=0 for a fourth x7 write; a write to x8 is still accepted while inflight<4.
- Same-cycle issue x3 and retire x3 with cnt[x3]=1 → cnt stays 1, busy stays 1, inflight unchanged.
- Issue with wreg=0, wd=1 → no busy for rsc=0; inflight +1.
- Four issues → issue_ready_o=0. flush_i with a simultaneous issue → next cycle inflight_o=0, all busy 0, the issue is ignored.
- Retire x9 with cnt 0 → err_o=1 and stays 1 through flush; async reset mid-cycle → err_o=0 immediately.
